// File: rtl/vram_text_pkg.sv
// Shared types and constants for the text VRAM writer.
package vram_text_pkg;

    typedef enum logic [1:0] {
        StClrAll,
        StIdle,
        StClrLine
    } state_e;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam int unsigned COLS_DEF  = 60;
    localparam int unsigned ROWS_DEF  = 17;
    localparam logic [7:0]  BLANK_DEF = 8'h20;

endpackage

// File: rtl/vram_row_base.sv
// Row index to VRAM base address (row * COLS) without a multiplier.
module vram_row_base #(
    parameter int unsigned COLS   = 60,
    parameter int unsigned ADDR_W = 10
) (
    input  logic [4:0]        row,
    output logic [ADDR_W-1:0] base
);

    logic [ADDR_W-1:0] row_w;
    assign row_w = ADDR_W'(row);

    if (COLS == 60) begin : g_shift_add
        assign base = (row_w << 6) - (row_w << 2);
    end else begin : g_generic
        // Sum of shifted copies for each set bit of COLS.
        always_comb begin
            base = '0;
            for (int i = 0; i < 32; i++) begin
                if (COLS[i]) base = base + (row_w << i);
            end
        end
    end

endmodule

// File: rtl/vram_text_writer.sv
// Byte-stream to text VRAM port-A writer with cursor, wrap, clear, BS and FF handling.
module vram_text_writer
    import vram_text_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  BLANK  = BLANK_DEF
) (
    input  logic              MEMORY_CLK,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              v_cea,
    output logic [ADDR_W-1:0] v_ada,
    output logic [7:0]        v_din,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] CNT_ALL_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] CNT_COL_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE      = ADDR_W'(1);
    localparam logic [5:0]        COL_LAST     = 6'(COLS - 1);
    localparam logic [4:0]        ROW_LAST     = 5'(ROWS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              cea_q, cea_d;
    logic [ADDR_W-1:0] ada_q, ada_d;
    logic [7:0]        din_q, din_d;

    logic [ADDR_W-1:0] base;
    logic [4:0]        row_next;

    vram_row_base #(
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_row_base (
        .row  (row_q),
        .base (base)
    );

    assign row_next = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        cea_d   = 1'b0;
        ada_d   = ada_q;
        din_d   = din_q;
        unique case (state_q)
            StClrAll: begin
                cea_d = 1'b1;
                ada_d = cnt_q;
                din_d = BLANK;
                if (cnt_q == CNT_ALL_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StClrLine: begin
                // row_q already holds the new row here
                cea_d = 1'b1;
                ada_d = base + cnt_q;
                din_d = BLANK;
                if (cnt_q == CNT_COL_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StIdle: begin
                if (in_valid) begin
                    if (in_data >= 8'h20) begin
                        cea_d = 1'b1;
                        ada_d = base + ADDR_W'(col_q);
                        din_d = in_data;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            row_d   = row_next;
                            state_d = StClrLine;
                            cnt_d   = '0;
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end else begin
                        case (in_data)
                            CH_LF: begin
                                col_d   = '0;
                                row_d   = row_next;
                                state_d = StClrLine;
                                cnt_d   = '0;
                            end
                            CH_CR: col_d = '0;
                            CH_BS: begin
                                if (col_q != 6'd0) begin
                                    col_d = col_q - 6'd1;
                                    cea_d = 1'b1;
                                    ada_d = base + ADDR_W'(col_q - 6'd1);
                                    din_d = BLANK;
                                end
                            end
                            CH_FF: begin
                                state_d = StClrAll;
                                cnt_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                state_d = StClrAll;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClrAll;
            cnt_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cea_q   <= 1'b0;
            ada_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cea_q   <= cea_d;
            ada_q   <= ada_d;
            din_q   <= din_d;
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign v_cea      = cea_q;
    assign v_ada      = ada_q;
    assign v_din      = din_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_vram_text_writer.sv
// Self-checking bench for vram_text_writer against a write-list model of the screen rules.
module tb_vram_text_writer;

    localparam int COLS = 60;
    localparam int ROWS = 17;
    localparam logic [7:0] BLANK = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       v_cea;
    logic [9:0] v_ada;
    logic [7:0] v_din;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    vram_text_writer dut (
        .MEMORY_CLK (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .v_cea      (v_cea),
        .v_ada      (v_ada),
        .v_din      (v_din),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int m_col = 0;
    int m_row = 0;

    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    int          got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v_cea) begin
            got_q.push_back({v_ada, v_din});
            got_cyc.push_back(cyc);
        end
    end

    task automatic push_exp(input int addr, input logic [7:0] d);
        logic [9:0] a;
        a = addr[9:0];
        exp_q.push_back({a, d});
    endtask

    task automatic model_advance();
        m_row = (m_row + 1) % ROWS;
        for (int i = 0; i < COLS; i++) push_exp(m_row * COLS + i, BLANK);
    endtask

    task automatic model_full_clear();
        for (int i = 0; i < COLS * ROWS; i++) push_exp(i, BLANK);
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20) begin
            push_exp(m_row * COLS + m_col, b);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                model_advance();
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            model_advance();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_exp(m_row * COLS + m_col, BLANK);
            end
        end else if (b == 8'h0C) begin
            model_full_clear();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 3000) begin
            n_err++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_byte(b);
    endtask

    // Wait for IDLE, then compare the captured write stream and cursor with the model.
    task automatic drain(input string name, output int low_cnt);
        int n = 0;
        bit bad_busy = 0;
        int idx = -1;
        low_cnt = 0;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            if (busy !== 1'b1) bad_busy = 1;
            low_cnt++;
            n++;
            @(negedge clk);
        end
        if (busy !== 1'b0) bad_busy = 1;
        #1;
        n_vec++;
        if (n >= 3000) begin
            n_err++;
            $display("FAIL %s_timeout: in_ready=%0b after %0d cycles, required 1", name, in_ready, n);
        end
        n_vec++;
        if (bad_busy) begin
            n_err++;
            $display("FAIL %s_busy: busy did not track clearing, required busy=!in_ready", name);
        end
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_count: %0d writes seen, required %0d", name, got_q.size(),
                     exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                if (idx < 0 && got_q[i] !== exp_q[i]) idx = i;
            end
            n_vec++;
            if (idx >= 0) begin
                n_err++;
                $display("FAIL %s_stream: write %0d addr=%0d data=%h, required addr=%0d data=%h",
                         name, idx, got_q[idx][17:8], got_q[idx][7:0], exp_q[idx][17:8],
                         exp_q[idx][7:0]);
            end
        end
        n_vec++;
        if (cursor_col !== 6'(m_col) || cursor_row !== 5'(m_row)) begin
            n_err++;
            $display("FAIL %s_cursor: (%0d,%0d), required (%0d,%0d)", name, cursor_col,
                     cursor_row, m_col, m_row);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if (v_cea !== 1'b0 || v_ada !== 10'd0 || v_din !== 8'd0 || cursor_col !== 6'd0 ||
            cursor_row !== 5'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s: cea=%b ada=%0d din=%h col=%0d row=%0d rdy=%b busy=%b, required 0 0 00 0 0 0 1",
                     name, v_cea, v_ada, v_din, cursor_col, cursor_row, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        int low;
        #12;
        check_reset_outputs("reset_values");
        got_q.delete();
        got_cyc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_full_clear();
        drain("clear_all", low);
        n_vec++;
        if (got_cyc.size() != COLS * ROWS ||
            got_cyc[got_cyc.size()-1] - got_cyc[0] != COLS * ROWS - 1) begin
            n_err++;
            $display("FAIL clear_all_contiguous: %0d pulses, required %0d back-to-back",
                     got_cyc.size(), COLS * ROWS);
        end
    endtask

    task automatic test_ab();
        int low;
        send_byte(8'h41);
        @(negedge clk);
        n_vec++;
        if (v_cea !== 1'b1 || v_ada !== 10'd0 || v_din !== 8'h41) begin
            n_err++;
            $display("FAIL latency_A: cea=%b ada=%0d din=%h, required 1 0 41", v_cea, v_ada, v_din);
        end
        drain("char_A", low);
        send_byte(8'h42);
        drain("char_B", low);
        n_vec++;
        if (cursor_col !== 6'd2) begin
            n_err++;
            $display("FAIL col_after_AB: %0d, required 2", cursor_col);
        end
    endtask

    task automatic test_line_feed();
        int low;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h0A);
            drain("lf_move", low);
        end
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(32, 255)));
        drain("lf_text", low);
        got_cyc.delete();
        send_byte(8'h0A);
        drain("lf_row3", low);
        n_vec++;
        if (low != COLS) begin
            n_err++;
            $display("FAIL lf_ready_low: %0d cycles, required %0d", low, COLS);
        end
        n_vec++;
        if (got_cyc.size() != COLS || got_cyc[got_cyc.size()-1] - got_cyc[0] != COLS - 1) begin
            n_err++;
            $display("FAIL lf_contiguous: %0d pulses, required %0d back-to-back", got_cyc.size(),
                     COLS);
        end
        n_vec++;
        if (cursor_row !== 5'd4 || cursor_col !== 6'd0) begin
            n_err++;
            $display("FAIL lf_cursor: (%0d,%0d), required (0,4)", cursor_col, cursor_row);
        end
    endtask

    task automatic test_wrap();
        int low;
        while (m_row != ROWS - 1) begin
            send_byte(8'h0A);
            drain("wrap_move", low);
        end
        for (int i = 0; i < COLS; i++) send_byte(8'($urandom_range(32, 255)));
        drain("wrap_bottom", low);
        n_vec++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            n_err++;
            $display("FAIL wrap_cursor: (%0d,%0d), required (0,0)", cursor_col, cursor_row);
        end
    endtask

    task automatic test_backspace();
        int low;
        send_byte(8'h08);
        drain("bs_col0", low);
        send_byte(8'h58);
        send_byte(8'h08);
        drain("bs_erase", low);
        n_vec++;
        if (cursor_col !== 6'd0) begin
            n_err++;
            $display("FAIL bs_col: %0d, required 0", cursor_col);
        end
    endtask

    task automatic test_random();
        int low;
        int r;
        logic [7:0] b;
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      b = 8'($urandom_range(32, 255));
            else if (r < 75) b = 8'h0A;
            else if (r < 85) b = 8'h08;
            else if (r < 90) b = 8'h0D;
            else begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h0C) b = 8'h07;
            end
            send_byte(b);
            drain("random", low);
        end
    endtask

    task automatic test_reset_mid();
        int low;
        send_byte(8'h0A);
        repeat (10) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: %b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset_values");
        m_col = 0;
        m_row = 0;
        repeat (3) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
        model_full_clear();
        drain("mid_restart", low);
        send_byte(8'h07);
        drain("bell_ignored", low);
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(32, 255)));
        drain("pre_ff", low);
        send_byte(8'h0C);
        drain("form_feed", low);
        n_vec++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            n_err++;
            $display("FAIL ff_home: (%0d,%0d), required (0,0)", cursor_col, cursor_row);
        end
    endtask

    initial begin
        test_reset();
        test_ab();
        test_line_feed();
        test_wrap();
        test_backspace();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
